// File: rtl/exception_ctrl.sv
//------------------------------------------------------------------------------
// exception_ctrl
//   Multicycle exception sequencer between the control unit and the PC/EPC
//   path. It accepts a qualified exception pulse and latches EPC and the
//   cause. It then reads the handler byte from the fixed vector location and
//   issues a one-cycle PC load with the zero-extended handler address.
//
//   Optional feature macro: EXC_LOST_CNT_EN adds the lost_cnt port, a
//   saturating count of events that arrive while a sequence is in progress.
//
// Parameters
//   VEC_OPCODE / VEC_OVF / VEC_DIV0 : byte addresses of the handler bytes
//   CNT_W                           : width of lost_cnt
//
// Ports
//   clk, reset            : clock; synchronous active-high reset
//   exc_opcode            : invalid-opcode pulse
//   exc_overflow          : signed-arithmetic overflow pulse
//   exc_div0              : divide-by-zero pulse
//   pc_in [31:0]          : PC of the faulting instruction plus 4
//   mem_rdata [31:0]      : memory read word, one cycle after the address
//   mem_addr [31:0]       : vector byte address, valid in FETCH/WAIT
//   mem_req               : memory read request, high in FETCH/WAIT
//   busy                  : sequence in progress, which stalls the control unit
//   pc_load               : one-cycle PC write strobe
//   pc_new [31:0]         : handler address
//   epc [31:0]            : exception program counter
//   cause [1:0]           : 0 none, 1 opcode, 2 overflow, 3 div0
//   lost_cnt [CNT_W-1:0]  : dropped-event count (EXC_LOST_CNT_EN only)
//------------------------------------------------------------------------------
module exception_ctrl #(
   parameter logic [31:0] VEC_OPCODE = 32'd253,
   parameter logic [31:0] VEC_OVF    = 32'd254,
   parameter logic [31:0] VEC_DIV0   = 32'd255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exc_opcode,
   input  logic              exc_overflow,
   input  logic              exc_div0,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       mem_addr,
   output logic              mem_req,
   output logic              busy,
   output logic              pc_load,
   output logic [31:0]       pc_new,
   output logic [31:0]       epc,
   output logic [1:0]        cause
`ifdef EXC_LOST_CNT_EN
   ,
   output logic [CNT_W-1:0]  lost_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_LOAD  = 2'd3
   } state_t;

   state_t      state;
   logic        any_exc;
   logic [1:0]  next_cause;
   logic [31:0] next_vec;
   logic [7:0]  sel_byte;

   if (CNT_W == 0) begin : g_cnt_w_invalid
      $error("exception_ctrl: CNT_W must be at least 1");
   end

   // Priority opcode > overflow > div0; lower-priority pulses on the same
   // edge are discarded.
   always_comb begin
      any_exc    = exc_opcode | exc_overflow | exc_div0;
      next_cause = 2'd0;
      next_vec   = '0;
      if (exc_opcode) begin
         next_cause = 2'd1;
         next_vec   = VEC_OPCODE;
      end else if (exc_overflow) begin
         next_cause = 2'd2;
         next_vec   = VEC_OVF;
      end else if (exc_div0) begin
         next_cause = 2'd3;
         next_vec   = VEC_DIV0;
      end
   end

   // Little-endian byte lane within the word returned for mem_addr.
   always_comb begin
      sel_byte = '0;
      case (mem_addr[1:0])
         2'b00: sel_byte = mem_rdata[7:0];
         2'b01: sel_byte = mem_rdata[15:8];
         2'b10: sel_byte = mem_rdata[23:16];
         2'b11: sel_byte = mem_rdata[31:24];
         default: sel_byte = '0;
      endcase
   end

   // All outputs are registered. They are set on the edge that enters the
   // state in which they must be valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         mem_addr <= '0;
         mem_req  <= 1'b0;
         busy     <= 1'b0;
         pc_load  <= 1'b0;
         pc_new   <= '0;
         epc      <= '0;
         cause    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_exc) begin
                  state    <= S_FETCH;
                  epc      <= pc_in - 32'd4;
                  cause    <= next_cause;
                  mem_addr <= next_vec;
                  mem_req  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               state    <= S_LOAD;
               pc_new   <= {24'b0, sel_byte};
               mem_addr <= '0;
               mem_req  <= 1'b0;
               pc_load  <= 1'b1;
            end
            S_LOAD: begin
               state   <= S_IDLE;
               pc_load <= 1'b0;
               busy    <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef EXC_LOST_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         lost_cnt <= '0;
      end else if (any_exc && (state != S_IDLE) && (lost_cnt != '1)) begin
         lost_cnt <= lost_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Multicycle exception sequencer that sits between the control unit and the PC/EPC path of the processor datapath. It accepts qualified exception pulses (invalid opcode, arithmetic overflow, divide by zero) and captures the faulting instruction address into EPC. It then fetches the handler address byte from the fixed vector location in memory and issues a one-cycle PC load with that address. While a sequence is in progress it holds `busy` so the control unit stalls.

## Interface
- `VEC_OPCODE`, default 253: byte address of the invalid-opcode handler byte.
- `VEC_OVF`, default 254: byte address of the overflow handler byte.
- `VEC_DIV0`, default 255: byte address of the divide-by-zero handler byte.
- `CNT_W`, default 8: width of the dropped-event counter (used only with `EXC_LOST_CNT_EN`).

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `exc_opcode` in 1: invalid-opcode pulse, already qualified by the control unit.
- `exc_overflow` in 1: ALU overflow pulse, asserted only for signed add/sub/addi.
- `exc_div0` in 1: divider divide-by-zero pulse.
- `pc_in` in 32: current PC value, already advanced by 4 past the faulting instruction.
- `mem_rdata` in 32: memory read word, valid one cycle after the address is sampled.
- `mem_addr` out 32: vector byte address; memory ignores bits [1:0].
- `mem_req` out 1: memory read request.
- `busy` out 1: a sequence is in progress; the control unit stalls.
- `pc_load` out 1: one-cycle PC write strobe.
- `pc_new` out 32: handler address, zero-extended vector byte.
- `epc` out 32: exception program counter.
- `cause` out 2: 0 = none, 1 = opcode, 2 = overflow, 3 = div0.
- `lost_cnt` out CNT_W: number of events dropped while busy (present only with the macro).

## Operation
- The FSM has four states: IDLE → FETCH → WAIT → LOAD → IDLE.
- **IDLE, on any exc_* pulse:**
  - `epc <= pc_in - 32'd4` (modulo 2^32).
  - `cause` is latched, with priority opcode > overflow > div0.
  - Next state is FETCH.
- **FETCH:**
  - `mem_addr` is the vector selected by `cause`.
  - `mem_req` = 1.
  - `busy` = 1.
- **WAIT:**
  - `mem_addr` and `mem_req` are held unchanged.
  - At the end of WAIT, `pc_new <= {24'b0, byte}`, where the byte is selected by `mem_addr[1:0]`: 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
- **LOAD:**
  - `pc_load` = 1 and `busy` = 1.
  - Next state is IDLE.
- **Outside FETCH/WAIT:**
  - `mem_addr` = 0 and `mem_req` = 0.
- **Held values:**
  - `epc` and `cause` hold until the next accepted event.
  - `pc_new` holds its last value.
- **Events outside IDLE** (FETCH, WAIT or LOAD) are ignored: no state change, and `epc`/`cause` are untouched.
- **Simultaneous pulses:** only the highest-priority event is taken. The others are discarded and are not counted as lost.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, `lost_cnt` = 0.
- **Latency:** the pulse is sampled at edge E0. Cycles after E0:
  - cycle 1: FETCH
  - cycle 2: WAIT
  - cycle 3: LOAD (`pc_load` high)
  - cycle 4: IDLE, ready for a new event
- `busy` is high for exactly 3 cycles, and `pc_load` for exactly 1.
- `epc` and `cause` are valid from cycle 1 onward.
- **Reset mid-sequence:** the FSM returns to IDLE at the next edge and `pc_load` never asserts. `epc`, `cause` and `pc_new` are cleared.
- **Reset and event on the same edge:** reset wins.
- **Back-to-back events:** a pulse in cycle 4 (IDLE) is accepted normally.

## Configuration
- **Macro `EXC_LOST_CNT_EN` defined:**
  - `lost_cnt` exists.
  - It increments by 1 for each edge on which any exc_* input is high while state ≠ IDLE and reset = 0.
  - It saturates at 2^CNT_W−1.
  - It is cleared only by reset.
- **Macro not defined:** the `lost_cnt` port and its logic are absent, and all other behaviour is identical.

## Test plan
Memory word at byte address 252 = 0x80604000, giving byte 253 = 0x40, byte 254 = 0x60, byte 255 = 0x80.

- **Invalid opcode:** pulse `exc_opcode` with `pc_in` = 0x24.
  - `epc` = 0x20, `cause` = 1, `mem_addr` = 253 in cycles 1–2.
  - `pc_load` = 1 in cycle 3 only, with `pc_new` = 0x40.
- **Priority:** pulse `exc_overflow` and `exc_div0` together, `pc_in` = 0x100.
  - `cause` = 2, `mem_addr` = 254, `pc_new` = 0x60, `epc` = 0xFC.
  - `lost_cnt` stays 0.
- **Busy drop:** pulse `exc_opcode`, then pulse `exc_div0` in cycle 2.
  - The first sequence completes with `pc_new` = 0x40 and `cause` stays 1.
  - A second `exc_div0` in cycle 4 gives `cause` = 3 and `pc_new` = 0x80.
  - With the macro, `lost_cnt` = 1.
- **Reset mid-operation:** assert `reset` during WAIT.
  - No `pc_load` pulse occurs.
  - Next cycle: `busy`, `epc`, `cause` and `pc_new` are all 0, and the FSM is in IDLE.
- **Wrap-around:** pulse `exc_overflow` with `pc_in` = 0x0.
  - `epc` = 0xFFFFFFFC and `pc_new` = 0x60.
- **Saturation (macro, CNT_W = 2):** hold the event inputs high continuously for 10 busy cycles.
  - `lost_cnt` stops at 3.
